cpu_sram_arbiter: RTL
=====================

Name:
cpu_sram_arbiter

Overview:
- Shares one sram-like bus (req / addr_ok / data_ok) between the instruction-fetch master (read-only) and the data master driven by the execute/memory stages.
- Tracks ordered outstanding transactions and routes each data_ok/rdata back to its owner, so the memory stage can consume cpu_data_rdata.
- Sits between the core pipeline and the single SRAM/bridge port.

Parameters:
- OUTSTANDING, 4: owner-FIFO depth, i.e. the maximum number of accepted-but-unanswered transactions. Must be a power of 2, at least 2.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request
- i_addr  in  32  fetch address
- i_addr_ok  out  1  fetch address accepted
- i_data_ok  out  1  fetch data returned
- i_rdata  out  32  fetch read data
- d_req  in  1  data request
- d_wr  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_addr_ok  out  1  data address accepted
- d_data_ok  out  1  data response (load data or store ack)
- d_rdata  out  32  load data
- s_req  out  1  bus request
- s_wr  out  1  bus write
- s_addr  out  32  bus address
- s_wdata  out  32  bus write data
- s_addr_ok  in  1  bus accepted the address
- s_data_ok  in  1  bus response, returned in order
- s_rdata  in  32  bus read data

Behaviour:
- Reset:
  - owner FIFO empty, count = 0, hold register clear.
  - All outputs are 0 while reset is asserted (s_req is forced to 0).
- Grant (combinational, zero latency):
  - If the hold register is valid, grant its stored owner.
  - Otherwise grant data if d_req, else fetch if i_req.
  - Fixed priority: data wins.
- Request:
  - s_req = grant_valid & ~full.
  - full is taken from the registered count only; a pop in the same cycle does not bypass it.
- Fetch grant: s_wr = 0, s_wdata = 0, s_addr = i_addr.
- Data grant: s_wr = d_wr, s_wdata = d_wdata, s_addr = d_addr.
- No grant: s_addr, s_wr and s_wdata are 0.
- Address handshake:
  - i_addr_ok = s_req & s_addr_ok & grant_is_fetch.
  - d_addr_ok = s_req & s_addr_ok & grant_is_data.
- Hold register:
  - Set, capturing the owner, when s_req & ~s_addr_ok.
  - Cleared on s_req & s_addr_ok.
  - Keeps s_req/s_addr stable until accepted; a late d_req cannot preempt a pending fetch.
- Push: on s_req & s_addr_ok, write the owner bit (1 = data) at the write pointer; count+1.
- Pop: on s_data_ok & ~empty, read the head owner; count-1.
  - d_data_ok = pop & head_is_data.
  - i_data_ok = pop & ~head_is_data.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Pointers wrap modulo OUTSTANDING.
- Read data: s_rdata is broadcast to both i_rdata and d_rdata; only the matching data_ok qualifies it.
- s_data_ok while empty: ignored; no state change, no underflow.
- Reset mid-operation: all in-flight ownership is discarded. Responses arriving after reset are ignored per the empty rule.

Decomposition:
- Shared package: OWNER_INST/OWNER_DATA encodings and the 32-bit address/data width constants.
- One natural sub-module, cpu_sram_owner_fifo: 1-bit-wide, OUTSTANDING-deep, with push/pop/full/empty/head.

Test Plan:
1. Fetch only:
   - Stimulus: i_req, i_addr = 0xBFC00000, s_addr_ok same cycle; s_data_ok 2 cycles later with s_rdata = 0x24080001.
   - Required: i_addr_ok = 1 in cycle 0; i_data_ok = 1 with i_rdata = 0x24080001; d_data_ok stays 0.
2. Contention:
   - Stimulus: i_req and d_req (load, 0x80000010) in the same cycle, s_addr_ok held 1.
   - Required: s_addr = 0x80000010 first, fetch address the next cycle; responses give d_data_ok then i_data_ok, in that order.
3. Hold:
   - Stimulus: i_req with s_addr_ok low for 3 cycles; d_req rises in cycle 1.
   - Required: s_addr stays the fetch address, and s_req stays 1, until addr_ok; the data address is issued in the following cycle.
4. Full:
   - Stimulus: OUTSTANDING = 4, four accepts with no s_data_ok, requests still pending.
   - Required: s_req = 0. One s_data_ok, then s_req = 1 in the next cycle, not the same cycle.
5. Store:
   - Stimulus: d_wr = 1, d_wdata = 0xDEADBEEF.
   - Required: s_wr = 1 and s_wdata = 0xDEADBEEF. A later fetch drives s_wr = 0 and s_wdata = 0.
6. Reset:
   - Stimulus: reset low with 2 transactions outstanding.
   - Required: count = 0 and s_req = 0; a stray s_data_ok after release raises neither i_data_ok nor d_data_ok.

Source files
------------

// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared definitions for the CPU-to-SRAM bus arbiter.
//   owner_e : the master that owns a transaction (fetch or data)
//   ADDR_W  : bus address width
//   DATA_W  : bus data width
package cpu_sram_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/cpu_sram_owner_fifo.sv
// Ordered record of which master owns each accepted-but-unanswered bus
// transaction. One bit per entry (1 = data master, 0 = fetch master).
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   push, push_owner     record a newly accepted transaction
//   pop                  retire the oldest transaction
//   full, empty          occupancy flags (from registered count)
//   head_owner           owner of the oldest transaction
module cpu_sram_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_owner,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head_owner
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en;

  assign full       = (count_q == CNT_FULL);
  assign empty      = (count_q == '0);
  assign head_owner = mem_q[rd_ptr_q];

  always_comb begin
    push_en  = push & ~full;
    pop_en   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_owner;
      // DEPTH is a power of two, so the pointer wraps by overflow.
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one sram-like bus between the instruction-fetch master (read only)
// and the data master. Data has fixed priority; an address that the bus has
// not yet accepted is held so a later data request cannot preempt it.
// Responses come back in order and are routed to their owner through a
// small owner FIFO.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   i_req/i_addr                     fetch request
//   i_addr_ok/i_data_ok/i_rdata      fetch handshake and read data
//   d_req/d_wr/d_addr/d_wdata        data request (load or store)
//   d_addr_ok/d_data_ok/d_rdata      data handshake and load data
//   s_req/s_wr/s_addr/s_wdata        shared bus request
//   s_addr_ok/s_data_ok/s_rdata      shared bus handshake and read data
module cpu_sram_arbiter
  import cpu_sram_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata
);

  logic   hold_valid_q, hold_valid_d;
  owner_e hold_owner_q, hold_owner_d;

  logic   grant_valid;
  owner_e grant_owner;
  logic   grant_fetch, grant_data;
  logic   addr_accept;
  logic   pop;
  logic   fifo_full, fifo_empty, fifo_head;

  always_comb begin
    grant_valid = hold_valid_q | d_req | i_req;
    if (hold_valid_q) begin
      grant_owner = hold_owner_q;
    end else if (d_req) begin
      grant_owner = OWNER_DATA;
    end else begin
      grant_owner = OWNER_INST;
    end

    // Reset gating keeps every output at 0 while reset is held, even though
    // the bus-side inputs may still be toggling.
    grant_fetch = reset & grant_valid & (grant_owner == OWNER_INST);
    grant_data  = reset & grant_valid & (grant_owner == OWNER_DATA);

    // full comes from the registered count only; a same-cycle response does
    // not open a slot until the next cycle.
    s_req = reset & grant_valid & ~fifo_full;

    s_addr  = '0;
    s_wr    = 1'b0;
    s_wdata = '0;
    if (grant_data) begin
      s_addr  = d_addr;
      s_wr    = d_wr;
      s_wdata = d_wdata;
    end else if (grant_fetch) begin
      s_addr = i_addr;
    end

    addr_accept = s_req & s_addr_ok;
    i_addr_ok   = addr_accept & grant_fetch;
    d_addr_ok   = addr_accept & grant_data;

    // A response with nothing outstanding is dropped.
    pop       = s_data_ok & ~fifo_empty;
    d_data_ok = reset & pop & (owner_e'(fifo_head) == OWNER_DATA);
    i_data_ok = reset & pop & (owner_e'(fifo_head) == OWNER_INST);
    i_rdata   = reset ? s_rdata : '0;
    d_rdata   = reset ? s_rdata : '0;

    hold_valid_d = hold_valid_q;
    hold_owner_d = hold_owner_q;
    if (addr_accept) begin
      hold_valid_d = 1'b0;
    end else if (s_req) begin
      hold_valid_d = 1'b1;
      hold_owner_d = grant_owner;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid_q <= 1'b0;
      hold_owner_q <= OWNER_INST;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_owner_q <= hold_owner_d;
    end
  end

  cpu_sram_owner_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_owner_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (addr_accept),
    .push_owner(grant_owner == OWNER_DATA),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_owner(fifo_head)
  );

endmodule
